// File: rtl/pipe_proc_rf_if.sv
// Instruction-in / result-out bundle for pipe_proc_rf.
// The slave side is the pipeline; the master side is the instruction source and result consumer.
interface pipe_proc_rf_if #(
    parameter int DW   = 8,
    parameter int NREG = 8
);
    localparam int RA = $clog2(NREG);
    localparam int IW = 3 + 3 * RA;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr;
    logic          res_valid;
    logic [DW-1:0] res;
    logic [RA-1:0] res_rd;
    logic          halted;

    modport master (
        output in_valid, instr,
        input  in_ready, res_valid, res, res_rd, halted
    );

    modport slave (
        input  in_valid, instr,
        output in_ready, res_valid, res, res_rd, halted
    );
endinterface

// File: rtl/pipe_proc_rf.sv
// Four-stage IF/ID/EX/WB toy processor with an internal register file and full forwarding.
// Operands are resolved in ID from EX, EX/WB, then the RF, so the pipe never stalls.
module pipe_proc_rf #(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    pipe_proc_rf_if.slave bus
);
    localparam int RA = $clog2(NREG);
    localparam int IW = 3 + 3 * RA;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    function automatic logic [DW-1:0] alu(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            default: alu = b;  // LDI carries its immediate in operand b
        endcase
    endfunction

    function automatic logic writes_rf(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_HALT);
    endfunction

    function automatic logic [DW-1:0] ldi_imm(input logic [2*RA-1:0] imm);
        logic [2*RA+DW-1:0] wide;
        wide = {{DW{1'b0}}, imm};
        return wide[DW-1:0];
    endfunction

    logic          halted_q, halted_d;
    logic          vld_p0_q, vld_p0_d;
    logic [IW-1:0] instr_p0_q, instr_p0_d;
    logic          vld_p1_q, vld_p1_d;
    logic [2:0]    op_p1_q, op_p1_d;
    logic [RA-1:0] rd_p1_q, rd_p1_d;
    logic [DW-1:0] opa_p1_q, opa_p1_d, opb_p1_q, opb_p1_d;
    logic          vld_p2_q, vld_p2_d;
    logic [2:0]    op_p2_q, op_p2_d;
    logic [RA-1:0] rd_p2_q, rd_p2_d;
    logic [DW-1:0] res_p2_q, res_p2_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_q, res_d;
    logic [RA-1:0] res_rd_q, res_rd_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic          accept;
    logic [2:0]    op_id;
    logic [RA-1:0] rd_id, rs1_id, rs2_id;
    logic [DW-1:0] alu_ex;
    logic          wr_ex, wr_p2;

    assign accept = bus.in_valid && !halted_q;
    assign op_id  = instr_p0_q[IW-1 -: 3];
    assign rd_id  = instr_p0_q[3*RA-1 -: RA];
    assign rs1_id = instr_p0_q[2*RA-1 -: RA];
    assign rs2_id = instr_p0_q[RA-1:0];
    assign alu_ex = alu(op_p1_q, opa_p1_q, opb_p1_q);
    assign wr_ex  = vld_p1_q && writes_rf(op_p1_q);
    assign wr_p2  = vld_p2_q && writes_rf(op_p2_q);

    always_comb begin
        halted_d   = halted_q || (accept && (bus.instr[IW-1 -: 3] == OP_HALT));
        // IF: a non-transfer cycle becomes a bubble
        vld_p0_d   = accept;
        instr_p0_d = bus.instr;
        // ID: later assignments take priority (EX over EX/WB over RF)
        vld_p1_d   = vld_p0_q;
        op_p1_d    = op_id;
        rd_p1_d    = rd_id;
        opa_p1_d   = rf_q[rs1_id];
        opb_p1_d   = rf_q[rs2_id];
        if (wr_p2 && (rd_p2_q == rs1_id)) opa_p1_d = res_p2_q;
        if (wr_p2 && (rd_p2_q == rs2_id)) opb_p1_d = res_p2_q;
        if (wr_ex && (rd_p1_q == rs1_id)) opa_p1_d = alu_ex;
        if (wr_ex && (rd_p1_q == rs2_id)) opb_p1_d = alu_ex;
        if (op_id == OP_LDI)              opb_p1_d = ldi_imm({rs1_id, rs2_id});
        // EX
        vld_p2_d   = vld_p1_q;
        op_p2_d    = op_p1_q;
        rd_p2_d    = rd_p1_q;
        res_p2_d   = alu_ex;
        // WB
        rf_d        = rf_q;
        res_valid_d = wr_p2;
        res_d       = res_q;
        res_rd_d    = res_rd_q;
        if (wr_p2) begin
            rf_d[rd_p2_q] = res_p2_q;
            res_d         = res_p2_q;
            res_rd_d      = rd_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q    <= 1'b0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_rd_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            halted_q    <= halted_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            res_rd_q    <= res_rd_d;
            rf_q        <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_p0_q <= instr_p0_d;
        op_p1_q    <= op_p1_d;
        rd_p1_q    <= rd_p1_d;
        opa_p1_q   <= opa_p1_d;
        opb_p1_q   <= opb_p1_d;
        op_p2_q    <= op_p2_d;
        rd_p2_q    <= rd_p2_d;
        res_p2_q   <= res_p2_d;
    end

    assign bus.in_ready  = !halted_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = res_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_pipe_proc_rf.sv
// Bench for pipe_proc_rf at DW=8/NREG=8 and DW=16/NREG=16: directed table, HALT and
// mid-flight reset sequences, then random traffic against a sequential-ISA model.
module tb_pipe_proc_rf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    int         cfg;
    logic       iv;
    logic [2:0] d_op;
    logic [3:0] d_rd, d_rs1, d_rs2;

    pipe_proc_rf_if #(.DW(8),  .NREG(8))  bus8();
    pipe_proc_rf_if #(.DW(16), .NREG(16)) bus16();

    pipe_proc_rf #(.DW(8),  .NREG(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    pipe_proc_rf #(.DW(16), .NREG(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    assign bus8.in_valid  = iv && (cfg == 0);
    assign bus8.instr     = {d_op, d_rd[2:0], d_rs1[2:0], d_rs2[2:0]};
    assign bus16.in_valid = iv && (cfg == 1);
    assign bus16.instr    = {d_op, d_rd, d_rs1, d_rs2};

    logic        a_rv, a_rdy, a_halt;
    logic [15:0] a_res;
    logic [3:0]  a_rd;
    assign a_rv   = (cfg == 0) ? bus8.res_valid : bus16.res_valid;
    assign a_rdy  = (cfg == 0) ? bus8.in_ready  : bus16.in_ready;
    assign a_halt = (cfg == 0) ? bus8.halted    : bus16.halted;
    assign a_res  = (cfg == 0) ? {8'h00, bus8.res} : bus16.res;
    assign a_rd   = (cfg == 0) ? {1'b0, bus8.res_rd} : bus16.res_rd;

    int nchecks = 0;
    int nerrs   = 0;

    // Architectural model: instructions execute in order at acceptance, retire 3 edges later.
    typedef struct {
        int          cyc;
        int unsigned rd;
        int unsigned val;
    } ret_t;
    ret_t        q[$];
    int unsigned m_rf[16];
    bit          m_halted;
    int unsigned last_res, last_rd;
    int          m_dw, m_ra, cyc;

    typedef struct {
        bit          v;
        int          op;
        int          rd;
        int          a;
        int          b;
        bit          ret;
        int unsigned e8;
        int unsigned e16;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        nchecks++;
        if (act != exp) begin
            nerrs++;
            $display("FAIL %s (cfg %0d, cyc %0d): got %0d expected %0d", nm, cfg, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 0;
        m_halted = 0;
        q.delete();
        last_res = 0;
        last_rd  = 0;
    endtask

    task automatic model_accept(input int op, input int rd, input int rs1, input int rs2);
        int unsigned mask, a, b, v;
        bit          wr;
        ret_t        r;
        mask = (m_dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_dw) - 1);
        a    = m_rf[rs1];
        b    = m_rf[rs2];
        v    = 0;
        wr   = 1;
        case (op)
            0: v = (a + b) & mask;
            1: v = (a - b) & mask;
            2: v = ((rs1 << m_ra) | rs2) & mask;
            3: v = a & b;
            4: v = a | b;
            5: v = a ^ b;
            6: wr = 0;
            default: begin wr = 0; m_halted = 1; end
        endcase
        if (wr) begin
            m_rf[rd] = v;
            r.cyc = cyc + 3;
            r.rd  = rd;
            r.val = v;
            q.push_back(r);
        end
    endtask

    task automatic model_check();
        chk("in_ready", a_rdy, !m_halted);
        chk("halted", a_halt, m_halted);
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("res_valid", a_rv, 1);
            chk("res", a_res, q[0].val);
            chk("res_rd", a_rd, q[0].rd);
            last_res = q[0].val;
            last_rd  = q[0].rd;
            void'(q.pop_front());
        end else begin
            chk("res_valid_idle", a_rv, 0);
            chk("res_hold", a_res, last_res);
            chk("res_rd_hold", a_rd, last_rd);
        end
    endtask

    task automatic cycle(input bit v, input int op, input int rd, input int rs1, input int rs2);
        bit acc;
        iv    = v;
        d_op  = op[2:0];
        d_rd  = rd[3:0];
        d_rs1 = rs1[3:0];
        d_rs2 = rs2[3:0];
        acc   = v && !m_halted;
        @(posedge clk);
        cyc++;
        if (acc) model_accept(op, rd, rs1, rs2);
        @(negedge clk);
        model_check();
    endtask

    task automatic ldi(input int rd, input int imm);
        cycle(1, 2, rd, imm >> m_ra, imm & ((1 << m_ra) - 1));
    endtask

    task automatic do_reset();
        iv  = 0;
        rst = 1;
        @(posedge clk);
        cyc++;
        model_reset();
        @(negedge clk);
        rst = 0;
        chk("rst_res_valid", a_rv, 0);
        chk("rst_res", a_res, 0);
        chk("rst_res_rd", a_rd, 0);
        chk("rst_halted", a_halt, 0);
        chk("rst_in_ready", a_rdy, 1);
    endtask

    task automatic add_row(input bit v, input int op, input int rd, input int a, input int b,
                           input bit ret, input int unsigned e8, input int unsigned e16);
        vec_t r;
        r.v = v; r.op = op; r.rd = rd; r.a = a; r.b = b;
        r.ret = ret; r.e8 = e8; r.e16 = e16;
        tbl.push_back(r);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].v && tbl[i].op == 2) ldi(tbl[i].rd, tbl[i].a);
            else cycle(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
            if (i >= 3) begin
                chk("tbl_valid", a_rv, tbl[i-3].ret);
                if (tbl[i-3].ret) begin
                    chk("tbl_res", a_res, (cfg == 0) ? tbl[i-3].e8 : tbl[i-3].e16);
                    chk("tbl_rd", a_rd, tbl[i-3].rd);
                end
            end
        end
    endtask

    task automatic run_random(input int n);
        int r, op, nreg;
        nreg = 1 << m_ra;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 9) == 0)) begin
                do_reset();
            end else begin
                r  = $urandom_range(0, 63);
                op = (r == 0) ? 7 : (r % 7);
                if ($urandom_range(0, 3) == 0)
                    cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, nreg - 1),
                          $urandom_range(0, nreg - 1), $urandom_range(0, nreg - 1));
                else
                    cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        rst = 1; iv = 0; cfg = 0; cyc = 0;
        d_op = 0; d_rd = 0; d_rs1 = 0; d_rs2 = 0;
        m_dw = 8; m_ra = 3;
        model_reset();

        // LDI rows give the immediate in field a; ALU rows give rs1, rs2 in a, b.
        add_row(1, 2, 1, 5, 0, 1, 5, 5);
        add_row(1, 2, 2, 3, 0, 1, 3, 3);
        add_row(1, 0, 3, 1, 2, 1, 8, 8);
        add_row(1, 2, 1, 7, 0, 1, 7, 7);
        add_row(1, 1, 2, 1, 1, 1, 0, 0);
        add_row(1, 0, 3, 2, 1, 1, 7, 7);
        add_row(1, 2, 1, 63, 0, 1, 63, 63);
        add_row(1, 0, 1, 1, 1, 1, 126, 126);
        add_row(1, 0, 1, 1, 1, 1, 252, 252);
        add_row(1, 0, 1, 1, 1, 1, 248, 504);
        add_row(1, 1, 2, 0, 1, 1, 8, 65032);
        add_row(1, 2, 1, 2, 0, 1, 2, 2);
        add_row(0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 0, 0, 0, 0, 0, 0);
        add_row(1, 6, 4, 1, 1, 0, 0, 0);
        add_row(1, 5, 4, 1, 1, 1, 0, 0);
        add_row(1, 2, 5, 9, 0, 1, 9, 9);
        add_row(1, 2, 5, 4, 0, 1, 4, 4);
        add_row(1, 0, 6, 5, 5, 1, 8, 8);
        add_row(1, 2, 1, 12, 0, 1, 12, 12);
        add_row(1, 2, 2, 10, 0, 1, 10, 10);
        add_row(1, 3, 3, 1, 2, 1, 8, 8);
        add_row(1, 4, 4, 1, 2, 1, 14, 14);
        add_row(1, 5, 5, 1, 2, 1, 6, 6);
        add_row(0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            cfg  = c;
            m_dw = (c == 0) ? 8 : 16;
            m_ra = (c == 0) ? 3 : 4;

            do_reset();
            run_table();

            // HALT: the ADD ahead of it retires, the LDI held behind it never does
            do_reset();
            ldi(1, 5);
            cycle(1, 0, 2, 1, 1);
            cycle(1, 7, 0, 0, 0);
            chk("halt_set", a_halt, 1);
            chk("halt_in_ready", a_rdy, 0);
            for (int i = 0; i < 6; i++) ldi(3, 9);
            chk("halt_sticky", a_halt, 1);
            do_reset();

            // Reset with three instructions in flight: nothing retires, RF reads back 0
            ldi(1, 7);
            ldi(2, 9);
            cycle(1, 0, 3, 1, 2);
            do_reset();
            for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
            cycle(1, 0, 4, 1, 2);
            cycle(1, 4, 5, 3, 1);
            for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

            run_random(1500);
            for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
            chk("drain_empty", q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
